// File: rtl/dma_pea_in_xbar.sv
// Input-stream crossbar: one fall-through FIFO per DMA read channel, broadcast to the PEA data inputs.
// Optional per-channel backpressure counters are built when MAGE_IN_XBAR_STALL_CNT_EN is defined.
module dma_pea_in_xbar #(
    parameter int unsigned N_CH       = 4,
    parameter int unsigned N_DIN      = 4,
    parameter int unsigned DW         = 32,
    parameter int unsigned FIFO_DEPTH = 4,
    localparam int unsigned SEL_W     = (N_CH > 1) ? $clog2(N_CH) : 1
) (
    input  logic                        clk_i,
    input  logic                        rst_n_i,
    input  logic                        clear_i,
    input  logic [N_CH-1:0]             dma_valid_i,
    input  logic [N_CH-1:0][DW-1:0]     dma_data_i,
    output logic [N_CH-1:0]             dma_ready_o,
    input  logic [N_DIN-1:0][SEL_W-1:0] sel_i,
    input  logic [N_DIN-1:0]            pea_en_i,
    input  logic [N_DIN-1:0]            pea_ready_i,
    output logic [N_DIN-1:0]            pea_valid_o,
    output logic [N_DIN-1:0][DW-1:0]    pea_data_o,
    output logic [N_DIN-1:0]            pea_take_o,
    output logic [N_CH-1:0][15:0]       stall_cnt_o
);

    localparam int unsigned PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int unsigned CNT_W = PTR_W + 1;

    logic [N_CH-1:0][FIFO_DEPTH-1:0][DW-1:0] mem_q, mem_d;
    logic [N_CH-1:0][PTR_W-1:0]              wr_ptr_q, wr_ptr_d;
    logic [N_CH-1:0][PTR_W-1:0]              rd_ptr_q, rd_ptr_d;
    logic [N_CH-1:0][CNT_W-1:0]              cnt_q, cnt_d;
    logic [N_CH-1:0]                         ready_q, ready_d;

    logic [N_CH-1:0] cons_c;
    logic [N_CH-1:0] grp_rdy_c;
    logic [N_CH-1:0] nonempty_c;
    logic [N_CH-1:0] push_c;
    logic [N_CH-1:0] pop_c;

    // Consumer groups: a word leaves only when every enabled reader of its channel is ready.
    always_comb begin
        cons_c     = '0;
        grp_rdy_c  = '1;
        nonempty_c = '0;
        push_c     = '0;
        pop_c      = '0;
        for (int unsigned c = 0; c < N_CH; c++) begin
            for (int unsigned p = 0; p < N_DIN; p++) begin
                if (pea_en_i[p] && (sel_i[p] == SEL_W'(c))) begin
                    cons_c[c]    = 1'b1;
                    grp_rdy_c[c] = grp_rdy_c[c] & pea_ready_i[p];
                end
            end
            nonempty_c[c] = (cnt_q[c] != '0);
            push_c[c]     = dma_valid_i[c] & ready_q[c];
            pop_c[c]      = nonempty_c[c] & cons_c[c] & grp_rdy_c[c];
        end
    end

    // FIFO next state; a flush discards any push or pop of the same cycle.
    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        cnt_d    = cnt_q;
        ready_d  = '0;
        for (int unsigned c = 0; c < N_CH; c++) begin
            if (clear_i) begin
                wr_ptr_d[c] = '0;
                rd_ptr_d[c] = '0;
                cnt_d[c]    = '0;
            end else begin
                if (push_c[c]) begin
                    mem_d[c][wr_ptr_q[c]] = dma_data_i[c];
                    wr_ptr_d[c]           = wr_ptr_q[c] + PTR_W'(1);
                end
                if (pop_c[c]) begin
                    rd_ptr_d[c] = rd_ptr_q[c] + PTR_W'(1);
                end
                cnt_d[c] = cnt_q[c] + CNT_W'(push_c[c]) - CNT_W'(pop_c[c]);
            end
            ready_d[c] = (cnt_d[c] < CNT_W'(FIFO_DEPTH)) && !clear_i;
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            mem_q    <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
            ready_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
            ready_q  <= ready_d;
        end
    end

    assign dma_ready_o = ready_q;

    // PEA side: fall-through head word of the selected channel.
    always_comb begin
        pea_valid_o = '0;
        pea_take_o  = '0;
        pea_data_o  = '0;
        for (int unsigned p = 0; p < N_DIN; p++) begin
            pea_data_o[p]  = mem_q[sel_i[p]][rd_ptr_q[sel_i[p]]];
            pea_valid_o[p] = pea_en_i[p] & nonempty_c[sel_i[p]];
            pea_take_o[p]  = pea_en_i[p] & pop_c[sel_i[p]];
        end
    end

`ifdef MAGE_IN_XBAR_STALL_CNT_EN
    logic [N_CH-1:0][15:0] stall_q, stall_d;

    // Saturating count of cycles a ready word waits on a lagging consumer.
    always_comb begin
        stall_d = stall_q;
        for (int unsigned c = 0; c < N_CH; c++) begin
            if (clear_i) begin
                stall_d[c] = '0;
            end else if (nonempty_c[c] && cons_c[c] && !grp_rdy_c[c] && (stall_q[c] != '1)) begin
                stall_d[c] = stall_q[c] + 16'd1;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            stall_q <= '0;
        end else begin
            stall_q <= stall_d;
        end
    end

    assign stall_cnt_o = stall_q;
`else
    assign stall_cnt_o = '0;
`endif

endmodule

// File: tb/tb_dma_pea_in_xbar.sv
// Randomized and directed bench for dma_pea_in_xbar against a queue-per-channel reference model.
module tb_dma_pea_in_xbar;

    localparam int unsigned N_CH       = 4;
    localparam int unsigned N_DIN      = 4;
    localparam int unsigned DW         = 16;
    localparam int unsigned FIFO_DEPTH = 4;
    localparam int unsigned SEL_W      = 2;

    typedef logic [DW-1:0] word_t;

    logic                        clk = 1'b0;
    logic                        rst_n;
    logic                        clear;
    logic [N_CH-1:0]             dma_valid;
    logic [N_CH-1:0][DW-1:0]     dma_data;
    logic [N_CH-1:0]             dma_ready;
    logic [N_DIN-1:0][SEL_W-1:0] sel;
    logic [N_DIN-1:0]            pea_en;
    logic [N_DIN-1:0]            pea_ready;
    logic [N_DIN-1:0]            pea_valid;
    logic [N_DIN-1:0][DW-1:0]    pea_data;
    logic [N_DIN-1:0]            pea_take;
    logic [N_CH-1:0][15:0]       stall_cnt;

    dma_pea_in_xbar #(
        .N_CH(N_CH), .N_DIN(N_DIN), .DW(DW), .FIFO_DEPTH(FIFO_DEPTH)
    ) dut (
        .clk_i(clk), .rst_n_i(rst_n), .clear_i(clear),
        .dma_valid_i(dma_valid), .dma_data_i(dma_data), .dma_ready_o(dma_ready),
        .sel_i(sel), .pea_en_i(pea_en), .pea_ready_i(pea_ready),
        .pea_valid_o(pea_valid), .pea_data_o(pea_data), .pea_take_o(pea_take),
        .stall_cnt_o(stall_cnt)
    );

    always #5 clk = ~clk;

    // Reference model: words in flight per channel, registered ready, stall counts.
    word_t       mq [N_CH][$];
    bit          m_ready [N_CH];
    int unsigned m_stall [N_CH];
    bit          m_pushed [N_CH];
    word_t       got [N_DIN][$];
    logic [N_DIN-1:0] last_take;
    logic [N_DIN-1:0] last_valid;

    int checks = 0;
    int errors = 0;

    task automatic chk_eq(input string tag, input logic [63:0] got_v, input logic [63:0] exp_v);
        checks++;
        if (got_v !== exp_v) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got_v, exp_v);
        end
    endtask

    function automatic bit m_cons(input int c);
        for (int p = 0; p < N_DIN; p++)
            if (pea_en[p] && (int'(sel[p]) == c)) return 1'b1;
        return 1'b0;
    endfunction

    function automatic bit m_grp(input int c);
        for (int p = 0; p < N_DIN; p++)
            if (pea_en[p] && (int'(sel[p]) == c) && !pea_ready[p]) return 1'b0;
        return 1'b1;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < N_CH; i++) begin
            mq[i].delete();
            m_ready[i]  = 1'b0;
            m_stall[i]  = 0;
            m_pushed[i] = 1'b0;
        end
    endtask

    task automatic clear_got();
        for (int p = 0; p < N_DIN; p++) got[p].delete();
    endtask

    // One cycle: check outputs shortly after the falling edge, then advance the model at the rising edge.
    task automatic step();
        bit pop_m [N_CH];
        bit push_m [N_CH];
        bit stl_m [N_CH];
        int c;
        logic [15:0] exp_stall;
        #1;
        for (int i = 0; i < N_CH; i++) begin
            pop_m[i]  = (mq[i].size() != 0) && m_cons(i) && m_grp(i);
            stl_m[i]  = (mq[i].size() != 0) && m_cons(i) && !m_grp(i);
            push_m[i] = dma_valid[i] && m_ready[i];
            chk_eq($sformatf("dma_ready[%0d]", i), 64'(dma_ready[i]), 64'(m_ready[i]));
`ifdef MAGE_IN_XBAR_STALL_CNT_EN
            exp_stall = 16'(m_stall[i]);
`else
            exp_stall = 16'd0;
`endif
            chk_eq($sformatf("stall_cnt[%0d]", i), 64'(stall_cnt[i]), 64'(exp_stall));
        end
        for (int p = 0; p < N_DIN; p++) begin
            c = int'(sel[p]);
            chk_eq($sformatf("pea_valid[%0d]", p), 64'(pea_valid[p]),
                   64'(pea_en[p] && (mq[c].size() != 0)));
            chk_eq($sformatf("pea_take[%0d]", p), 64'(pea_take[p]), 64'(pea_en[p] && pop_m[c]));
            if (pea_en[p] && (mq[c].size() != 0))
                chk_eq($sformatf("pea_data[%0d]", p), 64'(pea_data[p]), 64'(mq[c][0]));
            if (pea_take[p]) got[p].push_back(pea_data[p]);
        end
        last_take  = pea_take;
        last_valid = pea_valid;
        @(posedge clk);
        for (int i = 0; i < N_CH; i++) begin
            m_pushed[i] = 1'b0;
            if (clear) begin
                mq[i].delete();
                m_ready[i] = 1'b0;
                m_stall[i] = 0;
            end else begin
                if (stl_m[i] && (m_stall[i] < 65535)) m_stall[i]++;
                if (pop_m[i]) void'(mq[i].pop_front());
                if (push_m[i]) begin
                    mq[i].push_back(dma_data[i]);
                    m_pushed[i] = 1'b1;
                end
                m_ready[i] = (mq[i].size() < FIFO_DEPTH);
            end
        end
        @(negedge clk);
    endtask

    // DMA side: hold the word until it is accepted, bounded.
    task automatic push_word(input int ch, input word_t d);
        int n;
        n = 0;
        dma_valid[ch] = 1'b1;
        dma_data[ch]  = d;
        do begin
            step();
            n++;
        end while (!m_pushed[ch] && (n < 20));
        chk_eq($sformatf("push_accepted[%0d]", ch), 64'(m_pushed[ch]), 64'd1);
        dma_valid[ch] = 1'b0;
    endtask

    task automatic chk_all_zero(input string tag);
        chk_eq({tag, "_valid"}, 64'(pea_valid), 64'd0);
        chk_eq({tag, "_take"},  64'(pea_take),  64'd0);
        chk_eq({tag, "_data"},  64'(pea_data),  64'd0);
        chk_eq({tag, "_ready"}, 64'(dma_ready), 64'd0);
        chk_eq({tag, "_stall"}, 64'(stall_cnt), 64'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        logic [15:0] exp3;
        rst_n = 1'b1; clear = 1'b0;
        dma_valid = '0; dma_data = '0;
        sel = '0; pea_en = '0; pea_ready = '0;
        last_take = '0; last_valid = '0;
        model_reset();
        clear_got();
        #1 rst_n = 1'b0;
        #1 chk_all_zero("reset");
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        // Single channel stream
        sel[0] = 2'd0; pea_en[0] = 1'b1; pea_ready[0] = 1'b1;
        push_word(0, 16'h00A1);
        push_word(0, 16'h00A2);
        push_word(0, 16'h00A3);
        repeat (3) step();
        chk_eq("single_takes", 64'(got[0].size()), 64'd3);
        chk_eq("single_w0", 64'(got[0][0]), 64'h00A1);
        chk_eq("single_w1", 64'(got[0][1]), 64'h00A2);
        chk_eq("single_w2", 64'(got[0][2]), 64'h00A3);
        chk_eq("single_empty", 64'(pea_valid[0]), 64'd0);

        // Fill a channel with no consumer, then release it
        pea_en = '0; clear_got();
        for (int i = 0; i < 4; i++) push_word(1, word_t'(16'hB0 + i));
        chk_eq("fill_ready_low", 64'(dma_ready[1]), 64'd0);
        dma_valid[1] = 1'b1; dma_data[1] = 16'h00B4;
        repeat (3) step();
        chk_eq("fill_hold", 64'(dma_ready[1]), 64'd0);
        sel[1] = 2'd1; pea_en[1] = 1'b1; pea_ready[1] = 1'b1;
        n = 0;
        do begin step(); n++; end while (!m_pushed[1] && (n < 20));
        chk_eq("fill_5th_lat", 64'(n), 64'd2);
        dma_valid[1] = 1'b0;
        repeat (6) step();
        chk_eq("fill_takes", 64'(got[1].size()), 64'd5);
        for (int i = 0; i < 5; i++)
            chk_eq($sformatf("fill_w%0d", i), 64'(got[1][i]), 64'(16'hB0 + i));

        // Broadcast to two consumers, one lagging
        pea_en = '0; clear_got();
        sel[0] = 2'd0; sel[2] = 2'd0;
        pea_en[0] = 1'b1; pea_en[2] = 1'b1;
        pea_ready[0] = 1'b1; pea_ready[2] = 1'b0;
        push_word(0, 16'h0055);
        for (int i = 0; i < 3; i++) begin
            step();
            chk_eq("bcast_notake", 64'(last_take), 64'd0);
        end
`ifdef MAGE_IN_XBAR_STALL_CNT_EN
        exp3 = 16'd3;
`else
        exp3 = 16'd0;
`endif
        chk_eq("bcast_stall", 64'(stall_cnt[0]), 64'(exp3));
        pea_ready[2] = 1'b1;
        step();
        chk_eq("bcast_take", 64'(last_take), 64'(4'b0101));
        chk_eq("bcast_d0", 64'(got[0][0]), 64'h0055);
        chk_eq("bcast_d2", 64'(got[2][0]), 64'h0055);

        // Simultaneous push and pop, then no bypass into an empty FIFO
        pea_en = '0; pea_ready = '0; clear_got();
        sel[3] = 2'd2; pea_en[3] = 1'b1;
        push_word(2, 16'h00C0);
        push_word(2, 16'h00C1);
        pea_ready[3] = 1'b1;
        dma_valid[2] = 1'b1; dma_data[2] = 16'h00C2;
        step();
        dma_valid[2] = 1'b0;
        chk_eq("pp_take", 64'(last_take[3]), 64'd1);
        chk_eq("pp_ready", 64'(dma_ready[2]), 64'd1);
        repeat (4) step();
        chk_eq("pp_takes", 64'(got[3].size()), 64'd3);
        for (int i = 0; i < 3; i++)
            chk_eq($sformatf("pp_w%0d", i), 64'(got[3][i]), 64'(16'hC0 + i));
        sel[1] = 2'd3; pea_en[1] = 1'b1; pea_ready[1] = 1'b1;
        dma_valid[3] = 1'b1; dma_data[3] = 16'h00D0;
        step();
        dma_valid[3] = 1'b0;
        chk_eq("nobypass_valid", 64'(last_valid[1]), 64'd0);
        step();
        chk_eq("next_valid", 64'(last_valid[1]), 64'd1);
        chk_eq("next_data", 64'(got[1][0]), 64'h00D0);

        // Flush with words queued on two channels
        pea_en = '0; pea_ready = '0; clear_got();
        sel[0] = 2'd0; sel[1] = 2'd1; pea_en[0] = 1'b1; pea_en[1] = 1'b1;
        for (int i = 0; i < 3; i++) push_word(0, word_t'(16'hE0 + i));
        push_word(1, 16'h00E8);
        chk_eq("preclr_valid", 64'(pea_valid), 64'(4'b0011));
        clear = 1'b1;
        step();
        clear = 1'b0;
        chk_eq("clr_valid", 64'(pea_valid), 64'd0);
        chk_eq("clr_ready", 64'(dma_ready), 64'd0);
        step();
        chk_eq("clr_ready_back", 64'(dma_ready), 64'(4'hF));

        // Asynchronous reset in the middle of a burst
        pea_en = '0; pea_ready = '0; clear_got();
        sel[0] = 2'd0; pea_en[0] = 1'b1; pea_ready[0] = 1'b1;
        dma_valid[0] = 1'b1;
        for (int i = 0; i < 3; i++) begin
            dma_data[0] = word_t'($urandom);
            step();
        end
        #2 rst_n = 1'b0;
        #1 chk_all_zero("midrst");
        dma_valid = '0;
        model_reset();
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        clear_got();
        push_word(0, 16'h1234);
        repeat (2) step();
        chk_eq("rst_takes", 64'(got[0].size()), 64'd1);
        chk_eq("rst_word", 64'(got[0][0]), 64'h1234);

        // Randomized traffic against the model
        for (int cyc = 0; cyc < 2000; cyc++) begin
            if ((cyc % 100) == 0) begin
                for (int p = 0; p < N_DIN; p++) begin
                    sel[p]    = SEL_W'($urandom_range(0, N_CH - 1));
                    pea_en[p] = ($urandom_range(0, 3) != 0);
                end
            end
            dma_valid = N_CH'($urandom);
            for (int c = 0; c < N_CH; c++) dma_data[c] = word_t'($urandom);
            pea_ready = N_DIN'($urandom | $urandom);
            clear     = ($urandom_range(0, 63) == 0);
            step();
        end
        clear = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
